// File: rtl/uart_pkg.sv
// Shared UART definitions: byte width, byte type and the default receive FIFO depth.
package uart_pkg;

   localparam int UART_DATA_W        = 8;
   localparam int UART_RX_FIFO_DEPTH = 16;

   typedef logic [UART_DATA_W-1:0] uart_byte_t;

endpackage : uart_pkg

// File: rtl/uart_fifo_mem.sv
// DEPTH x byte storage for the receive FIFO: synchronous write, combinational read, no reset.
module uart_fifo_mem
   import uart_pkg::*;
#(
   parameter int DEPTH  = UART_RX_FIFO_DEPTH,
   parameter int ADDR_W = $clog2(DEPTH)
) (
   input  logic                   clk,
   input  logic                   we,
   input  logic [ADDR_W-1:0]      waddr,
   input  logic [UART_DATA_W-1:0] wdata,
   input  logic [ADDR_W-1:0]      raddr,
   output logic [UART_DATA_W-1:0] rdata
);

   uart_byte_t mem [DEPTH];

   always_ff @(posedge clk) begin
      if (we) begin
         mem[waddr] <= wdata;
      end
   end

   assign rdata = mem[raddr];

endmodule : uart_fifo_mem

// File: rtl/uart_rx_fifo.sv
// Receive byte buffer: captures ena_rxd strobes into a circular FIFO and presents them
// as a show-ahead valid/ready stream with level, full/empty and sticky overflow status.
module uart_rx_fifo
   import uart_pkg::*;
#(
   parameter int DEPTH  = UART_RX_FIFO_DEPTH,
   parameter int ADDR_W = $clog2(DEPTH)
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   ena_rxd,
   input  logic [UART_DATA_W-1:0] data_i,
   input  logic                   flush,
   input  logic                   clr_ovf,
   output logic [UART_DATA_W-1:0] m_data,
   output logic                   m_valid,
   input  logic                   m_ready,
   output logic [ADDR_W:0]        level,
   output logic                   full,
   output logic                   empty,
   output logic                   overflow
);

   localparam logic [ADDR_W:0]   FULL_LVL = (ADDR_W+1)'(DEPTH);
   localparam logic [ADDR_W:0]   LVL_ONE  = (ADDR_W+1)'(1);
   localparam logic [ADDR_W-1:0] PTR_ONE  = ADDR_W'(1);

   logic [ADDR_W-1:0] wr_ptr_q, rd_ptr_q;
   logic [ADDR_W:0]   level_q, level_d;
   logic              full_q, empty_q, ovf_q;
   logic              push, pop, wr_en, ovf_set;

   // Stream handshake: m_valid means m_data holds the oldest stored byte and stays
   // stable until accepted; a byte is consumed on any cycle where m_valid && m_ready.
   assign push = ena_rxd;
   assign pop  = m_valid & m_ready;

   // A full FIFO still accepts a byte when the head leaves in the same cycle.
   assign wr_en   = push & (~full_q | pop) & ~flush;
   assign ovf_set = push & full_q & ~pop & ~flush;

   always_comb begin
      level_d = level_q;
      if (flush) begin
         level_d = '0;
      end else begin
         unique case ({wr_en, pop})
            2'b10:   level_d = level_q + LVL_ONE;
            2'b01:   level_d = level_q - LVL_ONE;
            default: level_d = level_q;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         level_q  <= '0;
         full_q   <= 1'b0;
         empty_q  <= 1'b1;
         ovf_q    <= 1'b0;
      end else begin
         if (flush) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
         end else begin
            if (wr_en) wr_ptr_q <= wr_ptr_q + PTR_ONE;
            if (pop)   rd_ptr_q <= rd_ptr_q + PTR_ONE;
         end
         level_q <= level_d;
         full_q  <= (level_d == FULL_LVL);
         empty_q <= (level_d == '0);
         // A new drop outranks a concurrent clear.
         ovf_q   <= ovf_set | (ovf_q & ~clr_ovf);
      end
   end

   uart_fifo_mem #(
      .DEPTH  (DEPTH),
      .ADDR_W (ADDR_W)
   ) u_mem (
      .clk   (clk),
      .we    (wr_en),
      .waddr (wr_ptr_q),
      .wdata (data_i),
      .raddr (rd_ptr_q),
      .rdata (m_data)
   );

   assign m_valid  = ~empty_q;
   assign level    = level_q;
   assign full     = full_q;
   assign empty    = empty_q;
   assign overflow = ovf_q;

endmodule : uart_rx_fifo

// File: tb/tb_uart_rx_fifo.sv
// Directed plus randomized bench for uart_rx_fifo, checked against a queue-based model.
module tb_uart_rx_fifo;
   import uart_pkg::*;

   localparam int DEPTH  = 16;
   localparam int ADDR_W = $clog2(DEPTH);

   logic              clk = 1'b0;
   logic              rst_n;
   logic              ena_rxd;
   logic [7:0]        data_i;
   logic              flush;
   logic              clr_ovf;
   logic [7:0]        m_data;
   logic              m_valid;
   logic              m_ready;
   logic [ADDR_W:0]   level;
   logic              full;
   logic              empty;
   logic              overflow;

   logic [7:0] exp_q[$];
   logic       exp_ovf;
   int         total = 0;
   int         bad   = 0;

   uart_rx_fifo #(.DEPTH(DEPTH)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .ena_rxd  (ena_rxd),
      .data_i   (data_i),
      .flush    (flush),
      .clr_ovf  (clr_ovf),
      .m_data   (m_data),
      .m_valid  (m_valid),
      .m_ready  (m_ready),
      .level    (level),
      .full     (full),
      .empty    (empty),
      .overflow (overflow)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
      end
   endtask

   task automatic check_all(input string tag);
      int n;
      n = exp_q.size();
      chk({tag, " m_valid"},  32'(m_valid),  32'(n != 0));
      chk({tag, " level"},    32'(level),    32'(n));
      chk({tag, " full"},     32'(full),     32'(n == DEPTH));
      chk({tag, " empty"},    32'(empty),    32'(n == 0));
      chk({tag, " overflow"}, 32'(overflow), 32'(exp_ovf));
      if (n != 0) chk({tag, " m_data"}, 32'(m_data), 32'(exp_q[0]));
   endtask

   // Reference behaviour of one clock edge, using the inputs currently driven.
   task automatic model_edge();
      bit pop;
      bit drop;
      pop  = (exp_q.size() != 0) && m_ready;
      drop = 1'b0;
      if (flush) begin
         exp_q.delete();
      end else begin
         if (pop) void'(exp_q.pop_front());
         if (ena_rxd) begin
            if (exp_q.size() < DEPTH) exp_q.push_back(data_i);
            else                      drop = 1'b1;
         end
      end
      if (drop)         exp_ovf = 1'b1;
      else if (clr_ovf) exp_ovf = 1'b0;
   endtask

   // Drive one cycle from a negedge, model the edge, then check at the next negedge.
   task automatic step(input bit ena, input logic [7:0] d, input bit rdy,
                       input bit fl, input bit clr, input string tag);
      ena_rxd = ena;
      data_i  = d;
      m_ready = rdy;
      flush   = fl;
      clr_ovf = clr;
      @(posedge clk);
      model_edge();
      @(negedge clk);
      check_all(tag);
   endtask

   task automatic fill_to_full(input string tag);
      while (exp_q.size() < DEPTH) step(1'b1, 8'($urandom_range(0, 255)), 1'b0, 1'b0, 1'b0, tag);
   endtask

   initial begin
      rst_n   = 1'b0;
      ena_rxd = 1'b0;
      data_i  = 8'h00;
      flush   = 1'b0;
      clr_ovf = 1'b0;
      m_ready = 1'b0;
      exp_ovf = 1'b0;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;

      // reset then idle
      for (int i = 0; i < 20; i++) step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, "idle");

      // single byte, show-ahead, then one pop
      step(1'b1, 8'hA5, 1'b0, 1'b0, 1'b0, "single_push");
      chk("single_data", 32'(m_data), 32'h0000_00A5);
      step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, "single_pop");

      // fill 0x00..0x0F, drop 0x10, drain in order
      for (int i = 0; i < DEPTH; i++) step(1'b1, 8'(i), 1'b0, 1'b0, 1'b0, "fill");
      step(1'b1, 8'h10, 1'b0, 1'b0, 1'b0, "drop");
      chk("drop_ovf", 32'(overflow), 32'd1);
      for (int i = 0; i < DEPTH; i++) begin
         chk("drain_order", 32'(m_data), 32'(i));
         step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, "drain");
      end
      step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, "clr_alone");
      chk("clr_alone_ovf", 32'(overflow), 32'd0);

      // full with simultaneous push and pop
      fill_to_full("fill2");
      step(1'b1, 8'h55, 1'b1, 1'b0, 1'b0, "full_push_pop");
      chk("full_pp_level", 32'(level), 32'(DEPTH));
      for (int i = 0; i < DEPTH; i++) step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, "drain2");

      // overflow set beats clear; flush leaves overflow alone
      fill_to_full("fill3");
      step(1'b1, 8'h99, 1'b0, 1'b0, 1'b1, "set_vs_clr");
      chk("set_vs_clr_ovf", 32'(overflow), 32'd1);
      step(1'b0, 8'h00, 1'b0, 1'b1, 1'b0, "flush_a");
      for (int i = 0; i < 5; i++) step(1'b1, 8'(8'hE0 + i), 1'b0, 1'b0, 1'b0, "fill5");
      step(1'b1, 8'h77, 1'b0, 1'b1, 1'b0, "flush_push");
      chk("flush_level", 32'(level), 32'd0);
      chk("flush_ovf", 32'(overflow), 32'd1);
      step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, "after_flush");

      // asynchronous reset between edges
      for (int i = 0; i < 7; i++) step(1'b1, 8'(8'h30 + i), 1'b0, 1'b0, 1'b0, "fill7");
      ena_rxd = 1'b0;
      #1 rst_n = 1'b0;
      exp_q.delete();
      exp_ovf = 1'b0;
      #1 check_all("async_rst");
      #1 rst_n = 1'b1;
      @(negedge clk);
      step(1'b1, 8'h3C, 1'b0, 1'b0, 1'b0, "post_rst_push");
      chk("post_rst_data", 32'(m_data), 32'h0000_003C);
      step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, "post_rst_pop");

      // randomized traffic
      for (int i = 0; i < 600; i++) begin
         step(1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)),
              ($urandom_range(0, 99) < 40), ($urandom_range(0, 99) < 2),
              ($urandom_range(0, 99) < 5), "rand");
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule : tb_uart_rx_fifo
